// File: rtl/es_seq_unit_pkg.sv
// Shared types for the extend/shift unit: operation and state encodings.
package es_pkg;

    typedef enum logic [2:0] {
        ES_ELOS = 3'd0,
        ES_ELOU = 3'd1,
        ES_EHIZ = 3'd2,
        ES_SLL  = 3'd3,
        ES_SRL  = 3'd4,
        ES_SRA  = 3'd5,
        ES_ROL  = 3'd6,
        ES_ROR  = 3'd7
    } es_op_e;

    typedef enum logic [1:0] {
        ES_IDLE = 2'd0,
        ES_BUSY = 2'd1,
        ES_DONE = 2'd2
    } es_state_e;

    function automatic logic is_shift(input es_op_e op);
        return (op >= ES_SLL);
    endfunction

endpackage

// File: rtl/es_seq_unit_if.sv
// Request/result handshake bundle between issue logic, the unit and its consumer.
interface es_seq_unit_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMM_W   = 16,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         sel;
    logic [DATA_W-1:0]  a;
    logic [IMM_W-1:0]   imm;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  s;
    logic               busy;

    modport master (
        output in_valid, sel, a, imm, shamt, out_ready,
        input  in_ready, out_valid, s, busy
    );

    modport slave (
        input  in_valid, sel, a, imm, shamt, out_ready,
        output in_ready, out_valid, s, busy
    );
endinterface

// File: rtl/es_step_shifter.sv
// One iteration of the shift datapath: moves acc by d (0..STEP) positions.
module es_step_shifter
    import es_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STEP   = 4
) (
    input  logic [DATA_W-1:0]          i_acc,
    input  es_op_e                     i_op,
    input  logic [$clog2(STEP+1)-1:0]  i_d,
    output logic [DATA_W-1:0]          o_acc
);
    localparam int unsigned AW = $clog2(DATA_W) + 1;

    // Complementary distance for the wrap-around half of a rotate.
    logic [AW-1:0] w_inv;
    assign w_inv = AW'(DATA_W) - AW'(i_d);

    always_comb begin
        o_acc = i_acc;
        case (i_op)
            ES_SLL:  o_acc = i_acc << i_d;
            ES_SRL:  o_acc = i_acc >> i_d;
            ES_SRA:  o_acc = $signed(i_acc) >>> i_d;
            ES_ROL:  o_acc = (i_acc << i_d) | (i_acc >> w_inv);
            ES_ROR:  o_acc = (i_acc >> i_d) | (i_acc << w_inv);
            default: o_acc = i_acc;
        endcase
    end
endmodule

// File: rtl/es_seq_unit.sv
// Multi-cycle extend/shift unit: single-cycle extends, iterative shifts of up to STEP bits per cycle.
module es_seq_unit
    import es_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMM_W   = 16,
    parameter int unsigned STEP    = 4,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    es_seq_unit_if.slave     bus
);
    localparam int unsigned        DW     = $clog2(STEP + 1);
    localparam logic [SHAMT_W:0]   STEP_C = (SHAMT_W + 1)'(STEP);

    es_state_e          r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_acc;
    logic [SHAMT_W-1:0] r_rem;
    es_op_e             r_op;
    logic [DATA_W-1:0]  r_s;

    es_op_e             w_sel;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_multi;
    logic [DATA_W-1:0]  w_ext;
    logic [DW-1:0]      w_d;
    logic [SHAMT_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0]  w_step;

    assign w_sel      = es_op_e'(bus.sel);
    assign w_in_ready = !rst && !flush &&
                        ((r_state == ES_IDLE) || ((r_state == ES_DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_multi    = is_shift(w_sel) && (bus.shamt != '0);

    assign w_d        = ({1'b0, r_rem} < STEP_C) ? DW'(r_rem) : DW'(STEP);
    assign w_rem_nxt  = r_rem - SHAMT_W'(w_d);

    // Single-cycle result: extends, or a zero-distance shift passing a through.
    always_comb begin
        w_ext = bus.a;
        case (w_sel)
            ES_ELOS: w_ext = DATA_W'($signed(bus.imm));
            ES_ELOU: w_ext = DATA_W'(bus.imm);
            ES_EHIZ: w_ext = DATA_W'(bus.imm) << (DATA_W - IMM_W);
            default: w_ext = bus.a;
        endcase
    end

    es_step_shifter #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_step (
        .i_acc  (r_acc),
        .i_op   (r_op),
        .i_d    (w_d),
        .o_acc  (w_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ES_IDLE;
        end else begin
            case (r_state)
                ES_IDLE, ES_DONE: begin
                    if (w_accept)
                        w_state_nxt = w_multi ? ES_BUSY : ES_DONE;
                    else if ((r_state == ES_DONE) && bus.out_ready)
                        w_state_nxt = ES_IDLE;
                end
                ES_BUSY: begin
                    if (w_rem_nxt == '0)
                        w_state_nxt = ES_DONE;
                end
                default: w_state_nxt = ES_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ES_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_op    <= ES_ELOS;
            r_s     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!flush) begin
                if (w_accept) begin
                    if (w_multi) begin
                        r_acc <= bus.a;
                        r_rem <= bus.shamt;
                        r_op  <= w_sel;
                    end else begin
                        r_s   <= w_ext;
                    end
                end else if (r_state == ES_BUSY) begin
                    r_acc <= w_step;
                    r_rem <= w_rem_nxt;
                    if (w_rem_nxt == '0)
                        r_s <= w_step;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ES_DONE);
    assign bus.busy      = (r_state == ES_BUSY);
    assign bus.s         = r_s;

endmodule
